hfrv_mem_arbiter: RTL and testbench
===================================

# hfrv_mem_arbiter

Two-master arbiter sharing the single-port program/data SRAM of the hf-riscv DUT between the core memory port (master 0) and a debug/loader port (master 1), used by the testbench to preload or inspect memory while the core runs. Each granted request becomes one SRAM access. The arbiter waits a fixed memory latency, then returns the read data or write acknowledge to the owning master. It sits in `dut_top` between the core, the debug port and the memory model.

## Interface
- `AW`, 32: address width in bits.
- `DW`, 32: data width in bits; byte enables are `DW/8` wide.
- `MEM_LAT`, 1: SRAM read latency in cycles, legal range 1..4.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `m_req[1:0]`  in  2  per-master request; held until the matching `m_gnt` bit.
- `m_addr[2]`  in  2×AW  per-master byte address; stable while `m_req` is high.
- `m_wdata[2]`  in  2×DW  per-master write data.
- `m_be[2]`  in  2×DW/8  per-master byte write enables; all-zero means a read.
- `m_gnt[1:0]`  out  2  one-cycle grant pulse.
- `m_rvalid[1:0]`  out  2  one-cycle completion pulse.
- `m_rdata`  out  DW  read data, valid with `m_rvalid`, shared by both masters.
- `mem_en`  out  1  SRAM access strobe.
- `mem_addr`  out  AW  SRAM address.
- `mem_wdata`  out  DW  SRAM write data.
- `mem_we`  out  DW/8  SRAM byte write enables.
- `mem_rdata`  in  DW  SRAM read data, valid `MEM_LAT` cycles after `mem_en`.
- `owner`  out  1  index of the current or last owner, for the monitor.

## Operation
- FSM states:
  - IDLE: no access in progress. If any `m_req` bit is set, pick a winner, register its addr/wdata/be, and go to ISSUE.
  - ISSUE: `mem_en`=1 with the registered fields, and `m_gnt[winner]`=1. Load the latency counter with `MEM_LAT-1` and go to WAIT.
  - WAIT: count down. At zero, register `mem_rdata` into `m_rdata`, pulse `m_rvalid[winner]` next cycle, and go to IDLE.
- Only one access is in flight at a time; no pipelining.
- A master must drop or change `m_req` after it sees `m_gnt`. If `m_req` is still high in the next IDLE cycle, that is a new request.
- Writes also return `m_rvalid`. `m_rdata` on a write completion is don't-care but deterministic: it is the SRAM output.
- `m_addr` is passed through unaligned. Alignment is the master's responsibility.
- Winner selection is described under Configuration.

## Timing
- Reset values:
  - state=IDLE
  - `m_gnt`=0, `m_rvalid`=0, `m_rdata`=0
  - `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0
  - `owner`=0, round-robin pointer=0
- All outputs are registered.
- Request sampled at edge N produces `mem_en` and `m_gnt` at N+1, and `m_rvalid` at N+1+MEM_LAT+1. With `MEM_LAT`=1, the request-to-rvalid latency is 3 cycles.
- Peak throughput is one access per `MEM_LAT`+2 cycles.
- `mem_we` is forced to 0 in every state except ISSUE.
- `reset` asserted mid-access aborts the access:
  - no `m_rvalid` is produced;
  - an in-flight SRAM read is discarded;
  - an SRAM write already strobed stays written.
- Simultaneous requests are resolved the same cycle; the loser keeps `m_req` high and is served next.

## Configuration
- `HFRV_ARB_RR_EN` defined: round-robin. The pointer names the preferred master. After each grant the pointer moves to the other master, so two continuous requesters alternate 0,1,0,1.
- `HFRV_ARB_RR_EN` undefined: fixed priority, master 0 (core) always wins. The pointer register is not built. Master 1 can starve and is served only in IDLE cycles with `m_req[0]`=0.

## Structure
- Package `hfrv_arb_pkg`:
  - state enum `arb_state_t` {IDLE, ISSUE, WAIT};
  - master index constants `ARB_CORE`=0, `ARB_DEBUG`=1;
  - localparam `ARB_LAT_MAX`=4.
- Sub-module `hfrv_arb_pick`: combinational winner select from `m_req` and the pointer, including the `ifdef` on `HFRV_ARB_RR_EN`.
- Elaboration-time check: fatal if `MEM_LAT` is outside 1..4.

## Test plan
- Reset held for 3 cycles with both `m_req`=1 → no `m_gnt`, no `mem_en`, all outputs 0. Release → `m_gnt[0]` on the first cycle after release (both modes, pointer=0).
- Master 1 single write, addr 0x100, data 0xDEADBEEF, be 0xF, `MEM_LAT`=1 → `mem_en`/`mem_we`=0xF at +1, `m_rvalid[1]` at +3. A following master 1 read of 0x100 returns 0xDEADBEEF.
- Both masters requesting continuously for 8 accesses:
  - with `HFRV_ARB_RR_EN` → grant order 0,1,0,1,0,1,0,1;
  - without it → 8 grants to master 0, none to master 1.
- `MEM_LAT`=4, master 0 read → exactly 6 cycles from request sample to `m_rvalid[0]`; `mem_en` high for exactly 1 cycle.
- `reset` pulsed during WAIT of a master 1 read → no `m_rvalid`, state IDLE; the request re-presented afterwards completes normally.
- Byte write be=0x2, data 0x0000AB00 onto word 0x11223344 → readback 0x1122AB44.

Source files
------------

// File: rtl/hfrv_mem_arbiter_pkg.sv
// Shared types and constants for the hf-riscv two-master SRAM arbiter.
package hfrv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam logic ARB_CORE  = 1'b0;
  localparam logic ARB_DEBUG = 1'b1;

  localparam int ARB_LAT_MAX = 4;
  localparam int ARB_CNT_W   = $clog2(ARB_LAT_MAX);

endpackage

// File: rtl/hfrv_mem_arbiter_pick.sv
// Combinational winner select for the SRAM arbiter.
// HFRV_ARB_RR_EN selects round-robin; otherwise the core has fixed priority.
module hfrv_arb_pick
  import hfrv_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       win
);

`ifdef HFRV_ARB_RR_EN
  // ptr names the master preferred when both are requesting
  always_comb begin
    win = ARB_CORE;
    if (req == 2'b11) begin
      win = ptr;
    end else if (req[1]) begin
      win = ARB_DEBUG;
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ptr;

  always_comb begin
    win = ARB_CORE;
    if (req[1] && !req[0]) begin
      win = ARB_DEBUG;
    end
  end
`endif

endmodule

// File: rtl/hfrv_mem_arbiter.sv
// Two-master arbiter for the hf-riscv single-port SRAM: one access in flight.
// Build with HFRV_ARB_RR_EN for round-robin, default is fixed core priority.
//
// state | meaning
// IDLE  | no access in flight; pick a requester and latch its fields
// ISSUE | mem_en and m_gnt high for the latched access
// WAIT  | count down the SRAM latency, then return data and pulse m_rvalid
module hfrv_mem_arbiter
  import hfrv_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      m_req,
  input  logic [AW-1:0]   m_addr  [2],
  input  logic [DW-1:0]   m_wdata [2],
  input  logic [DW/8-1:0] m_be    [2],
  output logic [1:0]      m_gnt,
  output logic [1:0]      m_rvalid,
  output logic [DW-1:0]   m_rdata,
  output logic            mem_en,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_we,
  input  logic [DW-1:0]   mem_rdata,
  output logic            owner
);

  if (MEM_LAT < 1 || MEM_LAT > ARB_LAT_MAX) begin : g_lat_chk
    $fatal(1, "hfrv_mem_arbiter: MEM_LAT=%0d outside 1..%0d", MEM_LAT, ARB_LAT_MAX);
  end

  localparam logic [ARB_CNT_W-1:0] LAT_INIT = ARB_CNT_W'(MEM_LAT - 1);

  arb_state_t           state;
  logic [ARB_CNT_W-1:0] lat_cnt;
  logic                 ptr;
  logic                 win;

  hfrv_arb_pick u_pick (
    .req (m_req),
    .ptr (ptr),
    .win (win)
  );

`ifndef HFRV_ARB_RR_EN
  assign ptr = ARB_CORE;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      m_gnt     <= '0;
      m_rvalid  <= '0;
      m_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= '0;
      owner     <= ARB_CORE;
`ifdef HFRV_ARB_RR_EN
      ptr       <= ARB_CORE;
`endif
    end else begin
      // pulses and the write strobe only live for one cycle
      m_gnt    <= '0;
      m_rvalid <= '0;
      mem_en   <= 1'b0;
      mem_we   <= '0;
      case (state)
        IDLE: begin
          if (|m_req) begin
            owner      <= win;
            mem_addr   <= m_addr[win];
            mem_wdata  <= m_wdata[win];
            mem_we     <= m_be[win];
            mem_en     <= 1'b1;
            m_gnt[win] <= 1'b1;
            state      <= ISSUE;
`ifdef HFRV_ARB_RR_EN
            ptr        <= ~win;
`endif
          end
        end
        ISSUE: begin
          lat_cnt <= LAT_INIT;
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            m_rdata         <= mem_rdata;
            m_rvalid[owner] <= 1'b1;
            state           <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hfrv_mem_arbiter.sv
// Self-checking bench for hfrv_mem_arbiter: directed steps plus random accesses
// against a word-array memory model, one instance at MEM_LAT=1 and one at 4.
module tb_hfrv_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // MEM_LAT=1 instance
  logic [1:0]  m_req;
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_be    [2];
  logic [1:0]  m_gnt, m_rvalid;
  logic [31:0] m_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, owner;
  logic [3:0]  mem_we;

  hfrv_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_be(m_be), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  // MEM_LAT=4 instance
  logic [1:0]  req4;
  logic [31:0] addr4  [2];
  logic [31:0] wdata4 [2];
  logic [3:0]  be4    [2];
  logic [1:0]  gnt4, rv4;
  logic [31:0] rdata4, maddr4, mwdata4, mrdata4;
  logic        en4, owner4;
  logic [3:0]  mwe4;

  hfrv_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(4)) dut4 (
    .clk(clk), .reset(reset), .m_req(req4), .m_addr(addr4), .m_wdata(wdata4),
    .m_be(be4), .m_gnt(gnt4), .m_rvalid(rv4), .m_rdata(rdata4),
    .mem_en(en4), .mem_addr(maddr4), .mem_wdata(mwdata4), .mem_we(mwe4),
    .mem_rdata(mrdata4), .owner(owner4)
  );

  // SRAM models: read-before-write, data valid LAT cycles after the strobe
  logic [31:0] sram  [256] = '{default: '0};
  logic [31:0] sram4 [256] = '{5: 32'hCAFE_F00D, default: '0};
  logic [31:0] p1;
  logic [31:0] p4 [4];

  always @(posedge clk) begin
    p1 <= mem_en ? sram[mem_addr[9:2]] : 'x;
    if (mem_en)
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end
  assign mem_rdata = p1;

  always @(posedge clk) begin
    p4[0] <= en4 ? sram4[maddr4[9:2]] : 'x;
    for (int k = 1; k < 4; k++) p4[k] <= p4[k-1];
    if (en4)
      for (int b = 0; b < 4; b++)
        if (mwe4[b]) sram4[maddr4[9:2]][8*b +: 8] <= mwdata4[8*b +: 8];
  end
  assign mrdata4 = p4[3];

  // reference model
  logic [31:0] ref_mem [256] = '{default: '0};
  int pref = 0;
  int checks = 0;
  int failures = 0;

  function automatic int exp_winner();
`ifdef HFRV_ARB_RR_EN
    return pref;
`else
    return 0;
`endif
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int m, input int max, inout int n);
    bit got = 0;
    int k = 0;
    while (!got && k < max) begin
      tick(); k++;
      if (m_gnt[m]) got = 1;
    end
    n += k;
    check("gnt_seen", 64'(got), 64'd1);
  endtask

  task automatic wait_rv(input int m, input int max, inout int n);
    bit got = 0;
    int k = 0;
    while (!got && k < max) begin
      tick(); k++;
      if (m_rvalid[m]) got = 1;
    end
    n += k;
    check("rvalid_seen", 64'(got), 64'd1);
  endtask

  task automatic access(input int m, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd);
    int n = 0;
    logic [31:0] exp_rd;
    m_req[m] = 1'b1; m_addr[m] = a; m_wdata[m] = d; m_be[m] = be;
    wait_gnt(m, 20, n);
    m_req[m] = 1'b0;
    exp_rd = ref_mem[a[9:2]];
    ref_write(a, d, be);
    pref = 1 - m;
    wait_rv(m, 20, n);
    check("req_to_rvalid", 64'(n), 64'd3);
    rd = m_rdata;
    if (be == 4'h0) check("read_data", 64'(rd), 64'(exp_rd));
  endtask

  initial begin
    logic [31:0] rd, a, d;
    logic [3:0]  be;
    logic [1:0]  eg;
    int n, m, ngrant, nrv, ngrant1, cyc, ew, w, en_cnt, rv_cnt;
    bit got;
    int q[$];

    reset = 1'b1;
    m_req = 2'b11;
    m_addr[0] = 32'h100; m_addr[1] = 32'h104;
    m_wdata[0] = '0; m_wdata[1] = '0;
    m_be[0] = '0; m_be[1] = '0;
    req4 = '0;
    addr4[0] = '0; addr4[1] = '0; wdata4[0] = '0; wdata4[1] = '0; be4[0] = '0; be4[1] = '0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_gnt", 64'(m_gnt), 64'd0);
      check("reset_mem_en", 64'(mem_en), 64'd0);
    end
    check("reset_outputs", {m_rvalid, m_rdata, mem_we, owner}, 64'd0);
    check("reset_mem_bus", {mem_addr, mem_wdata}, 64'd0);

    // release with both requesting: master 0 first in both modes
    reset = 1'b0;
    tick();
    check("release_gnt", 64'(m_gnt), 64'b01);
    m_req[0] = 1'b0;
    pref = 1;
    n = 0;
    wait_rv(0, 10, n);
    check("release_rdata0", 64'(m_rdata), 64'd0);
    n = 0;
    wait_gnt(1, 10, n);
    m_req[1] = 1'b0;
    pref = 0;
    wait_rv(1, 10, n);
    check("release_rdata1", 64'(m_rdata), 64'd0);

    // master 1 full-word write, observing the SRAM strobe
    m_req[1] = 1'b1; m_addr[1] = 32'h100; m_wdata[1] = 32'hDEADBEEF; m_be[1] = 4'hF;
    n = 0;
    wait_gnt(1, 10, n);
    m_req[1] = 1'b0;
    check("wr_gnt_lat", 64'(n), 64'd1);
    check("wr_strobe", {mem_en, mem_we, mem_addr}, {1'b1, 4'hF, 32'h100});
    check("wr_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    ref_write(32'h100, 32'hDEADBEEF, 4'hF);
    pref = 0;
    tick(); n++;
    check("wr_strobe_off", {mem_en, mem_we}, 64'd0);
    wait_rv(1, 10, n);
    check("wr_rvalid_lat", 64'(n), 64'd3);
    check("wr_rvalid_only1", 64'(m_rvalid), 64'b10);
    access(1, 32'h100, 32'h0, 4'h0, rd);
    check("wr_readback", 64'(rd), 64'hDEADBEEF);

    // byte write into the middle lane
    access(0, 32'h200, 32'h11223344, 4'hF, rd);
    access(0, 32'h200, 32'h0000AB00, 4'h2, rd);
    access(0, 32'h200, 32'h0, 4'h0, rd);
    check("byte_merge", 64'(rd), 64'h1122AB44);

    // reset during WAIT of a master 1 read aborts it
    m_req[1] = 1'b1; m_addr[1] = 32'h100; m_be[1] = 4'h0;
    n = 0;
    wait_gnt(1, 10, n);
    m_req[1] = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("abort_rvalid", 64'(m_rvalid), 64'd0);
    reset = 1'b0;
    pref = 0;
    rv_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (m_rvalid != 2'b00) rv_cnt++;
      if (mem_en) rv_cnt++;
    end
    check("abort_quiet", 64'(rv_cnt), 64'd0);
    access(1, 32'h100, 32'h0, 4'h0, rd);
    check("abort_retry", 64'(rd), 64'hDEADBEEF);

    // both masters requesting continuously
    access(0, 32'h300, 32'h0A0A0A0A, 4'hF, rd);
    access(1, 32'h304, 32'h1B1B1B1B, 4'hF, rd);
    m_addr[0] = 32'h300; m_addr[1] = 32'h304; m_be[0] = 4'h0; m_be[1] = 4'h0;
    m_req = 2'b11;
    ngrant = 0; nrv = 0; ngrant1 = 0; cyc = 0;
    while ((ngrant < 8 || nrv < ngrant) && cyc < 200) begin
      tick(); cyc++;
      if (m_rvalid != 2'b00) begin
        w = q.pop_front();
        eg = 2'(1 << w);
        check("cont_rv_owner", 64'(m_rvalid), 64'(eg));
        check("cont_rdata", 64'(m_rdata), 64'(ref_mem[w == 0 ? 8'hC0 : 8'hC1]));
        nrv++;
      end
      if (m_gnt != 2'b00) begin
        ew = exp_winner();
        eg = 2'(1 << ew);
        check("grant_order", 64'(m_gnt), 64'(eg));
        q.push_back(ew);
        pref = 1 - ew;
        ngrant++;
        if (m_gnt[1]) ngrant1++;
        if (ngrant == 8) m_req = 2'b00;
      end
    end
    m_req = 2'b00;
    check("cont_rvalids", 64'(nrv), 64'd8);
`ifdef HFRV_ARB_RR_EN
    check("cont_m1_grants", 64'(ngrant1), 64'd4);
`else
    check("cont_m1_grants", 64'(ngrant1), 64'd0);
`endif

    // random single-master traffic
    for (int i = 0; i < 24; i++) begin
      m  = int'($urandom_range(0, 1));
      a  = 32'h300 + 32'($urandom_range(0, 7) << 2);
      be = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      d  = $urandom;
      access(m, a, d, be, rd);
    end

    // MEM_LAT=4 latency and single strobe
    req4[0] = 1'b1; addr4[0] = 32'h14; be4[0] = 4'h0;
    n = 0; en_cnt = 0; got = 0;
    while (!got && n < 20) begin
      tick(); n++;
      if (en4) en_cnt++;
      if (gnt4[0]) req4[0] = 1'b0;
      if (rv4[0]) got = 1;
    end
    req4[0] = 1'b0;
    check("lat4_rvalid_seen", 64'(got), 64'd1);
    check("lat4_latency", 64'(n), 64'd6);
    check("lat4_en_cycles", 64'(en_cnt), 64'd1);
    check("lat4_rdata", 64'(rdata4), 64'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
